seq_unsigned_divider: RTL

//   Sequential unsigned integer divider; the inverse operation to the team's 8-bit array multiplier.

---
 rtl/seq_unsigned_divider.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_unsigned_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock behind a
// start/busy/done handshake; divide-by-zero finishes in a single cycle.
module seq_unsigned_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    // The restored partial remainder is always < D, so it fits WIDTH bits; only
    // the shifted value needs the extra bit, which keeps all-ones/1 overflow-free.
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign a_sh = {a_q, q_q[WIDTH-1]};
    assign ge   = (a_sh >= {1'b0, d_q});
    assign diff = a_sh[WIDTH-1:0] - d_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_d = S_RUN;
                        a_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                    end else begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                a_d   = ge ? diff : a_sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = a_d;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
